// File: rtl/load_store_unit.sv
// load_store_unit: RV32 load/store sequencer between a CPU request/response port and a single-cycle memory.
// Optional build macro LSU_MISALIGNED_SPLIT_EN splits misaligned halfword/word accesses into byte accesses.
typedef enum logic [1:0] {BYTE = 2'd0, HALFWORD = 2'd1, WORD = 2'd2} tsize_e;

module load_store_unit #(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [2:0]    req_funct3,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [31:0]   resp_rdata,
    output logic          resp_error,
    output logic [AW-1:0] mem_address,
    output tsize_e        mem_tsize,
    output logic          mem_write,
    output logic [31:0]   mem_write_data,
    input  logic [31:0]   mem_data,
    input  logic          mem_rerror,
    input  logic          mem_werror
);
    typedef enum logic [2:0] {IDLE, LOAD, STORE, SCHECK, RESP} state_e;
    state_e        state_q, state_d;
    logic [2:0]    funct3_q, funct3_d;
    logic [31:0]   wdata_q, wdata_d, rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [AW-1:0] addr_q, addr_d;
    tsize_e        tsize_q, tsize_d;
    logic          accept, illegal, misaligned, bad, last;
    logic [31:0]   load_raw, load_ext;

    assign accept     = req_valid && req_ready;
    assign illegal    = req_write ? (req_funct3[2] || req_funct3[1:0] == 2'b11)
                                  : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
    assign misaligned = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                        (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);

`ifdef LSU_MISALIGNED_SPLIT_EN
    logic [1:0]  cnt_q, cnt_d, top;
    logic [23:0] asm_q, asm_d;
    logic        split_q, split_d;
    logic [7:0]  wbyte;

    // Byte k of a split access is the k-th most significant byte of the right-aligned value.
    assign top            = funct3_q[1] ? 2'd3 : 2'd1;
    assign last           = !split_q || cnt_q == top;
    assign bad            = illegal;
    assign wbyte          = 8'(wdata_q >> {top - cnt_q, 3'b000});
    assign load_raw       = split_q ? {asm_q, mem_data[7:0]} : mem_data;
    assign mem_write_data = split_q ? {24'd0, wbyte} : wdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            asm_q   <= '0;
            split_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            split_q <= split_d;
        end
    end
`else
    assign last           = 1'b1;
    assign bad            = illegal || misaligned;
    assign load_raw       = mem_data;
    assign mem_write_data = wdata_q;
`endif

    assign load_ext = funct3_q[1] ? load_raw :
                      funct3_q[0] ? {{16{~funct3_q[2] & load_raw[15]}}, load_raw[15:0]} :
                                    {{24{~funct3_q[2] & load_raw[7]}}, load_raw[7:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = !accept ? IDLE : bad ? RESP : req_write ? STORE : LOAD;
            LOAD:    state_d = last ? RESP : LOAD;
            STORE:   state_d = last ? SCHECK : STORE;
            SCHECK:  state_d = RESP;
            RESP:    state_d = resp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = state_q == IDLE;
        resp_valid = state_q == RESP;
        mem_write  = state_q == STORE;
    end

    assign resp_rdata  = rdata_q;
    assign resp_error  = err_q;
    assign mem_address = addr_q;
    assign mem_tsize   = tsize_q;

    always_comb begin
        funct3_d = funct3_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        addr_d   = addr_q;
        tsize_d  = tsize_q;
`ifdef LSU_MISALIGNED_SPLIT_EN
        cnt_d    = cnt_q;
        asm_d    = asm_q;
        split_d  = split_q;
`endif
        if (accept) begin
            funct3_d = req_funct3;
            wdata_d  = req_wdata;
            rdata_d  = '0;
            err_d    = bad;
            // Rejected requests never reach memory, so the memory-side address stays put.
            if (!bad) begin
                addr_d  = req_addr[AW-1:0];
`ifdef LSU_MISALIGNED_SPLIT_EN
                tsize_d = misaligned ? BYTE : tsize_e'(req_funct3[1:0]);
`else
                tsize_d = tsize_e'(req_funct3[1:0]);
`endif
            end
`ifdef LSU_MISALIGNED_SPLIT_EN
            cnt_d   = '0;
            asm_d   = '0;
            split_d = misaligned && !illegal;
`endif
        end
        if (state_q == LOAD) begin
            err_d = err_q || mem_rerror;
            if (last) rdata_d = (err_q || mem_rerror) ? '0 : load_ext;
        end
        if (state_q == SCHECK) err_d = err_q || mem_werror;
`ifdef LSU_MISALIGNED_SPLIT_EN
        // werror trails each byte write by one cycle; the final byte's flag lands in SCHECK.
        if (state_q == STORE && cnt_q != 2'd0) err_d = err_q || mem_werror;
        if ((state_q == LOAD || state_q == STORE) && split_q) begin
            cnt_d = last ? 2'd0 : cnt_q + 2'd1;
            if (!last) addr_d = addr_q + AW'(1);
            if (state_q == LOAD) asm_d = {asm_q[15:0], mem_data[7:0]};
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            funct3_q <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            tsize_q  <= BYTE;
        end else begin
            funct3_q <= funct3_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
            tsize_q  <= tsize_d;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed self-checking bench for load_store_unit against a byte-array memory model.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst, preload;
    logic        req_valid, req_ready, req_write, resp_valid, resp_ready, resp_error;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata, resp_rdata, mem_address, mem_write_data, mem_data;
    logic [1:0]  mem_tsize;
    logic        mem_write, mem_rerror, mem_werror;
    logic [7:0]  m [0:255];
    logic [7:0]  a;
    int          checks = 0, errors = 0;
    int          wr_cnt = 0, byte_cnt = 0, w0, b0;
    int          lat, wr, nb;

    always #5 clk = ~clk;

    load_store_unit #(.AW(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .mem_address(mem_address), .mem_tsize(mem_tsize), .mem_write(mem_write),
        .mem_write_data(mem_write_data), .mem_data(mem_data), .mem_rerror(mem_rerror),
        .mem_werror(mem_werror)
    );

    // Big-endian memory; addresses 0xF0-0xFF fault on both read and write.
    assign a          = mem_address[7:0];
    assign mem_rerror = a[7:4] == 4'hF;
    always_comb
        mem_data = mem_tsize == 2'd2 ? {m[a], m[a + 8'd1], m[a + 8'd2], m[a + 8'd3]} :
                   mem_tsize == 2'd1 ? {16'd0, m[a], m[a + 8'd1]} : {24'd0, m[a]};

    always @(posedge clk) begin
        mem_werror <= mem_write && a[7:4] == 4'hF;
        if (preload) begin
            for (int i = 0; i < 256; i++) m[i] <= 8'h00;
            {m[8'h10], m[8'h11], m[8'h12], m[8'h13]} <= 32'h80FF1234;
            {m[8'h21], m[8'h22], m[8'h23], m[8'h24]} <= 32'h11223344;
        end else if (mem_write) begin
            if (mem_tsize == 2'd2)      {m[a], m[a + 8'd1], m[a + 8'd2], m[a + 8'd3]} <= mem_write_data;
            else if (mem_tsize == 2'd1) {m[a], m[a + 8'd1]} <= mem_write_data[15:0];
            else                        m[a] <= mem_write_data[7:0];
        end
    end

    always @(negedge clk) begin
        if (mem_write) wr_cnt++;
        if (!req_ready && !resp_valid && !mem_write && mem_tsize == 2'd0) byte_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] ad, input logic [31:0] wd);
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = ad; req_wdata = wd;
        w0 = wr_cnt; b0 = byte_cnt;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic finish_resp();
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("req_ready_after_resp", {31'd0, req_ready}, 32'd1);
        resp_ready = 1'b0;
        wr = wr_cnt - w0;
        nb = byte_cnt - b0;
    endtask

    initial begin
        rst = 1'b1; preload = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
        req_write = 1'b0; req_funct3 = 3'd0; req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_error", {31'd0, resp_error}, 32'd0);
        chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        chk("rst_mem_tsize", {30'd0, mem_tsize}, 32'd0);
        chk("rst_mem_wdata", mem_write_data, 32'd0);
        @(negedge clk);
        rst = 1'b0; preload = 1'b0;

`ifdef LSU_MISALIGNED_SPLIT_EN
        issue(1'b0, 3'b010, 32'h21, 0);
        chk("split_lw_lat", lat, 5);
        chk("split_lw_rdata", resp_rdata, 32'h11223344);
        chk("split_lw_err", {31'd0, resp_error}, 32'd0);
        finish_resp();
        chk("split_lw_bytes", nb, 4);
        issue(1'b1, 3'b001, 32'h31, 32'h0000AABB);
        chk("split_sh_lat", lat, 4);
        chk("split_sh_err", {31'd0, resp_error}, 32'd0);
        finish_resp();
        chk("split_sh_writes", wr, 2);
        chk("split_sh_mem", {16'd0, m[8'h31], m[8'h32]}, 32'h0000AABB);
`endif

        issue(1'b0, 3'b001, 32'h10, 0);
        chk("lh_lat", lat, 2);
        chk("lh_rdata", resp_rdata, 32'hFFFF80FF);
        chk("lh_err", {31'd0, resp_error}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", {31'd0, resp_valid}, 32'd1);
            chk("hold_rdata", resp_rdata, 32'hFFFF80FF);
            chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        finish_resp();

        issue(1'b1, 3'b010, 32'h20, 32'hDEADBEEF);
        chk("sw_lat", lat, 3);
        chk("sw_err", {31'd0, resp_error}, 32'd0);
        chk("sw_rdata", resp_rdata, 32'd0);
        finish_resp();
        chk("sw_writes", wr, 1);

        issue(1'b0, 3'b100, 32'h23, 0);
        chk("lbu_lat", lat, 2);
        chk("lbu_rdata", resp_rdata, 32'h000000EF);
        finish_resp();

        issue(1'b0, 3'b000, 32'h11, 0);
        chk("lb_rdata", resp_rdata, 32'hFFFFFFFF);
        finish_resp();
        issue(1'b0, 3'b000, 32'h13, 0);
        chk("lb_pos_rdata", resp_rdata, 32'h00000034);
        finish_resp();
        issue(1'b0, 3'b101, 32'h10, 0);
        chk("lhu_rdata", resp_rdata, 32'h000080FF);
        finish_resp();
        issue(1'b0, 3'b010, 32'h10, 0);
        chk("lw_rdata", resp_rdata, 32'h80FF1234);
        finish_resp();
        chk("idle_mem_address", mem_address, 32'h10);
        chk("idle_mem_tsize", {30'd0, mem_tsize}, 32'd2);

        issue(1'b0, 3'b011, 32'h10, 0);
        chk("ill_ld_lat", lat, 1);
        chk("ill_ld_err", {31'd0, resp_error}, 32'd1);
        chk("ill_ld_rdata", resp_rdata, 32'd0);
        finish_resp();
        chk("ill_ld_writes", wr, 0);
        issue(1'b1, 3'b100, 32'h20, 32'h12345678);
        chk("ill_st_lat", lat, 1);
        chk("ill_st_err", {31'd0, resp_error}, 32'd1);
        finish_resp();
        chk("ill_st_writes", wr, 0);
        chk("ill_mem_address", mem_address, 32'h10);

`ifndef LSU_MISALIGNED_SPLIT_EN
        issue(1'b0, 3'b010, 32'h21, 0);
        chk("mis_lw_lat", lat, 1);
        chk("mis_lw_err", {31'd0, resp_error}, 32'd1);
        chk("mis_lw_rdata", resp_rdata, 32'd0);
        finish_resp();
        issue(1'b1, 3'b001, 32'h31, 32'h0000AABB);
        chk("mis_sh_lat", lat, 1);
        chk("mis_sh_err", {31'd0, resp_error}, 32'd1);
        finish_resp();
        chk("mis_sh_writes", wr, 0);
        chk("mis_sh_mem", {24'd0, m[8'h31]}, 32'd0);
`endif

        issue(1'b0, 3'b010, 32'hF0, 0);
        chk("rerr_lat", lat, 2);
        chk("rerr_err", {31'd0, resp_error}, 32'd1);
        chk("rerr_rdata", resp_rdata, 32'd0);
        finish_resp();
        issue(1'b1, 3'b000, 32'hF4, 32'h77);
        chk("werr_lat", lat, 3);
        chk("werr_err", {31'd0, resp_error}, 32'd1);
        finish_resp();

        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = 32'h55555555;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("abort_store_active", {31'd0, mem_write}, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_mem_write", {31'd0, mem_write}, 32'd0);
        chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
        chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_resp", {31'd0, resp_valid}, 32'd0);
        chk("abort_mem", {m[8'h40], m[8'h41], m[8'h42], m[8'h43]}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
